// File: rtl/ascii_decimal_tx.sv
// ascii_decimal_tx
//   Converts one unsigned binary word into decimal ASCII text for the UART
//   transmitter. The conversion is sequential shift-add-3 (double-dabble).
//   Leading zeros are suppressed, although a lone '0' is always kept.
//   The digits are then sent MSD first over a valid/ready byte handshake.
//   An optional terminator byte follows the last digit.
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous, active-high; aborts any sequence in progress
//   start     request, honoured only while idle
//   value     unsigned word captured together with an accepted start
//   busy      high while a sequence is in progress (not in the done cycle)
//   tx_data   ASCII byte offered to the transmitter
//   tx_valid  tx_data is valid; held until the transmitter takes it
//   tx_ready  transmitter accepts the byte on this edge
//   done      one-cycle pulse after the final byte has been accepted
module ascii_decimal_tx #(
  parameter int         DATA_WIDTH = 32,
  parameter int         DIGITS     = 10,
  parameter bit         TERM_EN    = 1'b1,
  parameter logic [7:0] TERM_CHAR  = 8'd13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] value,
  output logic                  busy,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  done
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] DIGITS_CNT = CNT_W'(DIGITS);
  localparam logic [CNT_W-1:0] ONE_CNT    = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_SKIP,
    S_SEND,
    S_TERM,
    S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [BCD_W-1:0]      bcd, bcd_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]      digit_cnt, digit_cnt_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_nxt;
  logic [7:0]            tx_data_nxt;
  logic                  xfer;

  // Add 3 to every BCD digit >= 5, so that the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? (b[4*i +: 4] + 4'd3) : b[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic [7:0] ascii_digit(input logic [3:0] nib);
    return 8'd48 + {4'd0, nib};
  endfunction

  // tx_valid is registered and is high exactly while in SEND/TERM.
  assign xfer = tx_valid && tx_ready;

  always_comb begin
    state_nxt     = state;
    bcd_nxt       = bcd;
    shreg_nxt     = shreg;
    digit_cnt_nxt = digit_cnt;
    bit_cnt_nxt   = bit_cnt;
    tx_data_nxt   = 8'd0;

    case (state)
      S_IDLE: begin
        if (start) begin
          shreg_nxt     = value;
          bcd_nxt       = '0;
          digit_cnt_nxt = DIGITS_CNT;
          bit_cnt_nxt   = '0;
          state_nxt     = S_CONVERT;
        end
      end
      S_CONVERT: begin
        {bcd_nxt, shreg_nxt} = {dabble_adjust(bcd), shreg} << 1;
        bit_cnt_nxt = bit_cnt + BIT_W'(1);
        if (bit_cnt == LAST_BIT) begin
          state_nxt = S_SKIP;
        end
      end
      S_SKIP: begin
        // Drop one leading zero per cycle, but keep at least one digit.
        if ((bcd[BCD_W-1 -: 4] == 4'd0) && (digit_cnt > ONE_CNT)) begin
          bcd_nxt       = bcd << 4;
          digit_cnt_nxt = digit_cnt - ONE_CNT;
        end else begin
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (xfer) begin
          bcd_nxt       = bcd << 4;
          digit_cnt_nxt = digit_cnt - ONE_CNT;
          if (digit_cnt == ONE_CNT) begin
            state_nxt = TERM_EN ? S_TERM : S_DONE;
          end
        end
      end
      S_TERM: begin
        if (xfer) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state, so the byte shown in SEND is
    // the top digit of the BCD register as it will stand after this edge.
    if (state_nxt == S_SEND) begin
      tx_data_nxt = ascii_digit(bcd_nxt[BCD_W-1 -: 4]);
    end else if (state_nxt == S_TERM) begin
      tx_data_nxt = TERM_CHAR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      bcd       <= '0;
      shreg     <= '0;
      digit_cnt <= '0;
      bit_cnt   <= '0;
      busy      <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'd0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bcd       <= bcd_nxt;
      shreg     <= shreg_nxt;
      digit_cnt <= digit_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      busy      <= (state_nxt == S_CONVERT) || (state_nxt == S_SKIP) ||
                   (state_nxt == S_SEND)    || (state_nxt == S_TERM);
      tx_valid  <= (state_nxt == S_SEND) || (state_nxt == S_TERM);
      tx_data   <= tx_data_nxt;
      done      <= (state_nxt == S_DONE);
    end
  end

endmodule
